// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg -- shared definitions for the micro-programmed multicycle
// controller: micro-state encodings, opcode constants, write-register select
// encodings and dispatch-table indices.
//
// Optional feature macro: MICRO_SEQ_JAL_EN (enables the JAL micro-state).
package micro_seq_pkg;

  // Micro-program counter values; the numeric values are architectural.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JAL    = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  // Instruction-register opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Write-register mux select (10 is never produced).
  localparam logic [1:0] RDS_RT = 2'b00;
  localparam logic [1:0] RDS_RD = 2'b01;
  localparam logic [1:0] RDS_RA = 2'b11;

  // Dispatch-table index.
  localparam logic TBL_DECODE = 1'b0;
  localparam logic TBL_MEMADR = 1'b1;

endpackage

// File: rtl/micro_dispatch.sv
// micro_dispatch -- combinational dispatch ROMs used by micro_seq.
//
// Ports:
//   opcode   in  [5:0]  instruction opcode field
//   tbl_sel  in         dispatch table: 0 = DECODE table, 1 = MEMADR table
//   next_upc out [3:0]  dispatched micro-program counter
//
// Macro MICRO_SEQ_JAL_EN adds the JAL entry to the DECODE table; without it
// opcode 000011 falls through to HALT like any other unknown opcode.
module micro_dispatch
  import micro_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       tbl_sel,
  output logic [3:0] next_upc
);

  always_comb begin
    next_upc = S_HALT;
    if (tbl_sel == TBL_DECODE) begin
      case (opcode)
        OP_RTYPE:      next_upc = S_EXEC;
        OP_LW, OP_SW:  next_upc = S_MEMADR;
        OP_BEQ:        next_upc = S_BRANCH;
        OP_J:          next_upc = S_JUMP;
        OP_ADDI:       next_upc = S_ADDIEX;
`ifdef MICRO_SEQ_JAL_EN
        OP_JAL:        next_upc = S_JAL;
`endif
        default:       next_upc = S_HALT;
      endcase
    end else begin
      // An opcode that changed between DECODE and MEMADR is treated as illegal.
      case (opcode)
        OP_LW:   next_upc = S_MEMRD;
        OP_SW:   next_upc = S_MEMWR;
        default: next_upc = S_HALT;
      endcase
    end
  end

endmodule

// File: rtl/micro_seq.sv
// micro_seq -- micro-programmed control sequencer for a multicycle MIPS-like
// datapath. The micro-program counter upc is the FSM state and is exported
// directly, so it doubles as the state debug view.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode [5:0]      IR opcode field, sampled in DECODE and MEMADR
//   zero              ALU zero flag (consumed externally with pc_write_cond)
//   mem_ready         memory handshake completion
//   upc [3:0]         current micro-program counter
//   reg_dst_sel [1:0] write-register select: 00 rt, 01 rd, 11 r31
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_write, alu_src_a           1-bit datapath controls
//   alu_src_b, alu_op, pc_source [1:0]         2-bit datapath controls
//   illegal           sticky unknown-opcode flag
//
// Handshake: FETCH, MEMRD and MEMWR hold while mem_ready=0; the access
// completes in the cycle mem_ready=1, and only that cycle carries the
// ir_write / pc_write (FETCH) or mem_write (MEMWR) strobe.
//
// Macro MICRO_SEQ_JAL_EN enables the jal micro-state (upc 12).
module micro_seq
  import micro_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] upc,
  output logic [1:0] reg_dst_sel,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal
);

  state_t     state;
  state_t     state_next;
  logic [3:0] disp_upc;
  logic       tbl_sel;

  // Raw strobes before reset gating.
  logic pc_write_raw, pc_write_cond_raw, mem_write_raw, ir_write_raw, reg_write_raw;

  // zero only qualifies pc_write_cond in the datapath; it is not needed here.
  logic unused_zero;
  assign unused_zero = zero;

  assign tbl_sel = (state == S_MEMADR) ? TBL_MEMADR : TBL_DECODE;

  micro_dispatch u_dispatch (
    .opcode   (opcode),
    .tbl_sel  (tbl_sel),
    .next_upc (disp_upc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_HALT) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_next = state_t'(disp_upc);
      S_MEMADR: state_next = state_t'(disp_upc);
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_RWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    reg_dst_sel       = RDS_RT;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    iord              = 1'b0;
    mem_read          = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    mem_to_reg        = 1'b0;
    reg_write_raw     = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_source         = 2'b00;
    case (state)
      S_FETCH: begin
        // PC+4 through the ALU while the instruction is read.
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        // Branch target precompute: PC + (sign-extended imm << 2).
        alu_src_b = 2'b11;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_dst_sel   = RDS_RT;
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_dst_sel   = RDS_RD;
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_source         = 2'b01;
        pc_write_cond_raw = 1'b1;
      end
      S_JUMP: begin
        pc_source    = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_ADDIWB: begin
        reg_dst_sel   = RDS_RT;
        reg_write_raw = 1'b1;
      end
`ifdef MICRO_SEQ_JAL_EN
      S_JAL: begin
        // Link register r31 is written with the already-incremented PC.
        reg_dst_sel   = RDS_RA;
        reg_write_raw = 1'b1;
        pc_source     = 2'b10;
        pc_write_raw  = 1'b1;
      end
`endif
      default: begin
        // HALT and unused encodings drive no strobes.
      end
    endcase
  end

  // Reset is applied combinationally to the write strobes so nothing fires
  // while rst_n is low, even though FETCH would otherwise follow mem_ready.
  assign upc           = state;
  assign pc_write      = pc_write_raw      & rst_n;
  assign pc_write_cond = pc_write_cond_raw & rst_n;
  assign mem_write     = mem_write_raw     & rst_n;
  assign ir_write      = ir_write_raw      & rst_n;
  assign reg_write     = reg_write_raw     & rst_n;

endmodule

// File: tb/tb_micro_seq.sv
// tb_micro_seq -- directed bench for micro_seq. Each driven cycle pushes the
// hand-computed expected output vector; a negedge monitor pops and compares.
// Vector layout: {upc, reg_dst_sel, reg_write, mem_to_reg, pc_write,
//                 pc_write_cond, ir_write, mem_write, pc_source, illegal}
module tb_micro_seq;
  localparam int W = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [3:0] upc;
  logic [1:0] reg_dst_sel, alu_src_b, alu_op, pc_source;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a, illegal;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  micro_seq dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .upc(upc), .reg_dst_sel(reg_dst_sel), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Strobe field order: {rw, m2r, pcw, pcwc, irw, mw}
  function automatic logic [W-1:0] ev(input logic [3:0] u, input logic [1:0] rds,
                                      input logic [5:0] st, input logic [1:0] pcs,
                                      input logic ill);
    return {u, rds, st, pcs, ill};
  endfunction

  // Drivers
  task automatic step(input logic [5:0] op, input logic mr, input logic z,
                      input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(e);
  endtask

  // Asserts reset asynchronously mid-cycle with mem_ready high; every output
  // must read back as the reset state in that same cycle.
  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    exp_q.push_back(ev(4'd0, 2'b00, 6'b000000, 2'b00, 1'b0));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    if (exp_q.size() > 0) begin
      got  = {upc, reg_dst_sel, reg_write, mem_to_reg, pc_write, pc_write_cond,
              ir_write, mem_write, pc_source, illegal};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL ctrl_vec check#%0d: got upc=%0d rds=%b st=%b pcs=%b ill=%b, want upc=%0d rds=%b st=%b pcs=%b ill=%b",
                 checks, got[14:11], got[10:9], got[8:3], got[2:1], got[0],
                 want[14:11], want[10:9], want[8:3], want[2:1], want[0]);
      end
    end
  end

  localparam logic [5:0] R  = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AD = 6'b001000;
  localparam logic [5:0] JL = 6'b000011, BAD = 6'b111111;

  initial begin
    // Reset state with mem_ready high: no strobes.
    rst_pulse();

    // R-type: 0,1,6,7
    step(R, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(R, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(R, 1, 0, ev(4'd6, 2'b00, 6'b000000, 2'b00, 0));
    step(R, 1, 0, ev(4'd7, 2'b01, 6'b100000, 2'b00, 0));

    // lw with 3 wait cycles in FETCH: 0x4, 1,2,3,4
    for (int i = 0; i < 3; i++)
      step(LW, 0, 0, ev(4'd0, 2'b00, 6'b000000, 2'b00, 0));
    step(LW, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(LW, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(LW, 1, 0, ev(4'd2, 2'b00, 6'b000000, 2'b00, 0));
    step(LW, 1, 0, ev(4'd3, 2'b00, 6'b000000, 2'b00, 0));
    step(LW, 1, 0, ev(4'd4, 2'b00, 6'b110000, 2'b00, 0));

    // sw with one wait in MEMWR: 0,1,2,5(wait),5
    step(SW, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(SW, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(SW, 1, 0, ev(4'd2, 2'b00, 6'b000000, 2'b00, 0));
    step(SW, 0, 0, ev(4'd5, 2'b00, 6'b000000, 2'b00, 0));
    step(SW, 1, 0, ev(4'd5, 2'b00, 6'b000001, 2'b00, 0));

    // beq zero=0, then zero=1: 0,1,8 each
    for (int z = 0; z < 2; z++) begin
      step(BQ, 1, z[0], ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
      step(BQ, 1, z[0], ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
      step(BQ, 1, z[0], ev(4'd8, 2'b00, 6'b000100, 2'b01, 0));
    end

    // j: 0,1,9
    step(JP, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(JP, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(JP, 1, 0, ev(4'd9, 2'b00, 6'b001000, 2'b10, 0));

    // addi: 0,1,10,11
    step(AD, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(AD, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(AD, 1, 0, ev(4'd10, 2'b00, 6'b000000, 2'b00, 0));
    step(AD, 1, 0, ev(4'd11, 2'b00, 6'b100000, 2'b00, 0));

    // jal
    step(JL, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(JL, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
`ifdef MICRO_SEQ_JAL_EN
    step(JL, 1, 0, ev(4'd12, 2'b11, 6'b101000, 2'b10, 0));
    step(R,  1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    rst_pulse();
`else
    step(JL, 1, 0, ev(4'd13, 2'b00, 6'b000000, 2'b00, 1));
    step(JL, 1, 0, ev(4'd13, 2'b00, 6'b000000, 2'b00, 1));
    rst_pulse();
`endif

    // Illegal opcode: 0,1,13,13 then reset clears illegal immediately.
    step(BAD, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(BAD, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(BAD, 1, 0, ev(4'd13, 2'b00, 6'b000000, 2'b00, 1));
    step(BAD, 1, 0, ev(4'd13, 2'b00, 6'b000000, 2'b00, 1));
    rst_pulse();

    // Reset during MEMRD of a lw, then a clean R-type restart.
    step(LW, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(LW, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(LW, 1, 0, ev(4'd2, 2'b00, 6'b000000, 2'b00, 0));
    step(LW, 0, 0, ev(4'd3, 2'b00, 6'b000000, 2'b00, 0));
    rst_pulse();
    step(R, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));
    step(R, 1, 0, ev(4'd1, 2'b00, 6'b000000, 2'b00, 0));
    step(R, 1, 0, ev(4'd6, 2'b00, 6'b000000, 2'b00, 0));
    step(R, 1, 0, ev(4'd7, 2'b01, 6'b100000, 2'b00, 0));
    step(R, 1, 0, ev(4'd0, 2'b00, 6'b001010, 2'b00, 0));

    // Drain: wait (bounded) for the monitor to consume every expectation.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/micro_seq.md
MICRO_SEQ -- requirements
Module: micro_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction-register opcode field, sampled in DECODE and MEMADR.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag, used only in BRANCH.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory handshake completion.
REQ-006 SHALL have port upc, output, 4 bits: current micro-program counter.
REQ-007 SHALL have port reg_dst_sel, output, 2 bits: select for the 5-bit 4:1 write-register mux. 00 = rt, 01 = rd, 11 = constant 31, 10 never driven.
REQ-008 SHALL have the following control ports, all outputs: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a (1 bit each); alu_src_b, alu_op, pc_source (2 bits each).
REQ-009 SHALL have port illegal, output, 1 bit: sticky unknown-opcode flag.

Function
REQ-010 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, JAL=12, HALT=13.
REQ-011 SHALL compute all control outputs combinationally from upc only, except for the handshake gating in REQ-012.
REQ-012 SHALL hold upc in FETCH, MEMRD and MEMWR while mem_ready=0; ir_write, pc_write and mem_write SHALL be asserted only in the cycle mem_ready=1.
REQ-013 SHALL use the following next-state rules: FETCH->DECODE. DECODE dispatches on opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, 000011->JAL (REQ-024); any other opcode->HALT.
REQ-014 SHALL go MEMADR->MEMRD for lw and MEMADR->MEMWR for sw, then MEMRD->MEMWB.
REQ-015 SHALL go EXEC->RWB and ADDIEX->ADDIWB.
REQ-016 SHALL return MEMWB, MEMWR, RWB, ADDIWB, BRANCH, JUMP and JAL to FETCH in one cycle.
REQ-017 SHALL drive reg_dst_sel=01 in RWB, 00 in MEMWB and ADDIWB, 11 in JAL, and 00 in all other states.
REQ-018 SHALL assert reg_write only in RWB, MEMWB, ADDIWB and JAL; mem_to_reg=1 only in MEMWB.
REQ-019 SHALL assert pc_write_cond only in BRANCH, with pc_source=01; the PC updates externally only when zero=1.
REQ-020 SHALL drive pc_source=10 and pc_write=1 in JUMP and JAL.
REQ-021 SHALL set illegal on entry to HALT; upc SHALL stay 13 with all write strobes 0 until reset.
REQ-022 SHALL follow a unit latency of one clock per micro-state plus wait cycles. Instruction counts: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, jal 3, each with mem_ready tied high.

Reset
REQ-023 SHALL, while rst_n=0, force upc=0 and illegal=0, and hold pc_write, pc_write_cond, ir_write, mem_write and reg_write at 0 regardless of mem_ready. Asserting reset mid-instruction SHALL abandon the instruction, with no partial write strobe after the reset edge.

Configuration
REQ-024 SHALL, with macro MICRO_SEQ_JAL_EN defined, dispatch opcode 000011 to JAL, which writes the link register via reg_dst_sel=11 and jumps. Without the macro, opcode 000011 SHALL go to HALT and set illegal; state 12 is unreachable and reg_dst_sel is never 11.

Structure
REQ-025 SHALL place state encodings, opcode constants and reg_dst_sel encodings in shared package micro_seq_pkg.
REQ-026 SHALL implement the DECODE and MEMADR dispatch tables in sub-module micro_dispatch: purely combinational, inputs opcode and dispatch-table index, output next upc.

Verification
REQ-027 The bench SHALL cover an R-type instruction: opcode 000000, mem_ready=1 -> upc 0,1,6,7,0; reg_dst_sel=01 and reg_write=1 only in the RWB cycle.
REQ-028 The bench SHALL cover lw with a 3-cycle FETCH wait: opcode 100011, mem_ready low 3 cycles -> upc held at 0 for 4 cycles with ir_write=0 until mem_ready=1, then 1,2,3,4,0; reg_dst_sel=00 in MEMWB.
REQ-029 The bench SHALL cover beq: opcode 000100, zero=0 -> upc 0,1,8,0, with pc_write_cond=1 and pc_source=01 in state 8.
REQ-030 The bench SHALL cover jal with MICRO_SEQ_JAL_EN defined and undefined: opcode 000011 -> defined: upc 0,1,12,0 with reg_dst_sel=11, reg_write=1, pc_write=1; undefined: upc 0,1,13,13 with illegal=1.
REQ-031 The bench SHALL cover an illegal opcode and reset mid-instruction: opcode 111111 -> HALT with illegal=1. rst_n pulsed low during MEMRD -> upc=0, illegal=0 immediately, with no write strobe asserted.
